hk_mem_ctrl: RTL and testbench
==============================

Name: hk_mem_ctrl

Overview:
- Sequencer and arbiter in front of the H/K constant memory (MOD_HK_MEM).
- After reset it drives the ROM-to-RAM copy and waits for completion. It then shares the single HK read port between two requesters: the H-side (hash init / final add) and the K-side (round engine).
- Owns HK_SELECTOR, H_ADDR and K_ADDR. Holds them stable for the memory read latency, then returns the 32-bit word with a one-cycle valid strobe.

Parameters:
- READ_LAT, 1: cycles from memory address/selector change to HK valid; legal range 1..7.
- COPY_TIMEOUT, 1024: max cycles in COPY before raising COPY_ERR; legal range 1..65535.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- REINIT  in  1  level; request a fresh ROM copy.
- MEM_COPY_ROM  out  1  to memory COPY_ROM.
- MEM_COPY_DONE  in  1  from memory COPY_ROM_COMPLETE.
- MEM_HK_SEL  out  1  to memory HK_SELECTOR; 0 = H, 1 = K.
- MEM_H_ADDR  out  3  to memory H_ADDR.
- MEM_K_ADDR  out  6  to memory K_ADDR.
- MEM_HK  in  32  memory read data.
- READY  out  1  copy done and no copy error.
- COPY_ERR  out  1  sticky; set when the copy times out.
- H_REQ  in  1  H read request.
- H_RADDR  in  3  H index.
- H_GNT  out  1  one-cycle accept pulse for H.
- H_VALID  out  1  one-cycle data strobe for H.
- K_REQ  in  1  K read request.
- K_RADDR  in  6  K index.
- K_GNT  out  1  one-cycle accept pulse for K.
- K_VALID  out  1  one-cycle data strobe for K.
- RD_DATA  out  32  read data; valid while H_VALID or K_VALID is high.

Behaviour:
- Reset (RST_N low, asynchronous):
  - State = COPY. MEM_COPY_ROM=1. All other outputs 0: READY, COPY_ERR, GNTs, VALIDs, MEM_HK_SEL, MEM_H_ADDR, MEM_K_ADDR, RD_DATA.
  - last_grant = K, so H wins the first tie. Timeout and latency counters = 0.
- States: COPY, IDLE, WAIT, RESP, ERR.
- COPY:
  - MEM_COPY_ROM=1; timeout counter increments each cycle.
  - MEM_COPY_DONE sampled high -> IDLE; MEM_COPY_ROM=0 and READY=1 from the next cycle.
  - Counter reaches COPY_TIMEOUT without MEM_COPY_DONE -> ERR; COPY_ERR=1, MEM_COPY_ROM=0.
  - No grants are issued in COPY.
- ERR: terminal until REINIT is high. REINIT -> COPY; clears COPY_ERR, resets the counter, sets MEM_COPY_ROM=1.
- IDLE:
  - REINIT high has priority over requests -> COPY; READY=0.
  - Else, if any REQ is high, pick a winner. Only one requesting -> it wins. Both requesting -> the side not equal to last_grant wins.
  - Winner's GNT pulses this cycle. Its address is latched into MEM_H_ADDR or MEM_K_ADDR; MEM_HK_SEL is set; last_grant is updated; go to WAIT.
  - Loser keeps waiting; its REQ must stay high until its GNT.
- WAIT:
  - Latency counter counts READ_LAT cycles with selector and address held constant.
  - REINIT is ignored until the read completes.
- RESP:
  - RD_DATA <= MEM_HK. The winner's VALID pulses for exactly one cycle.
  - Next state is IDLE, or COPY if REINIT is high.
- Timing:
  - GNT at cycle t -> VALID at cycle t+READ_LAT+1.
  - Back-to-back reads: one accept per READ_LAT+2 cycles.
- Data and address hold:
  - RD_DATA holds its last value outside VALID.
  - The unselected address output retains its last value.
- Only one of H_GNT/K_GNT and only one of H_VALID/K_VALID is ever high.
- REQ is held high after GNT -> treated as a new request in the next IDLE. Requesters drop REQ on the GNT cycle for single reads.
- REINIT asserted during WAIT/RESP: the in-flight read completes and its VALID is delivered, then COPY.
- MEM_COPY_DONE is ignored outside COPY.
- Address wrap: none internally. Requesters supply every index; 3-bit and 6-bit fields, no range checks needed.

Decomposition:
- Shared package (hk_pkg):
  - State encoding: COPY=0, IDLE=1, WAIT=2, RESP=3, ERR=4.
  - Selector constants: HSEL=0, KSEL=1.
  - Widths: H_AW=3, K_AW=6, HK_W=32.
- One natural sub-module, hk_rr_arb: 2-way round-robin arbiter taking the two REQs and last_grant, producing a one-hot grant.
- Everything else stays in hk_mem_ctrl.

Test Plan:
- Reset, MEM_COPY_DONE asserted after 200 cycles (real MOD_HK_MEM attached) -> MEM_COPY_ROM=1 throughout, READY=1 one cycle after done, no GNT before READY.
- H_REQ with H_RADDR=0, then 7 -> H_VALID at GNT+2 (READ_LAT=1), RD_DATA=6a09e667 then 5be0cd19; MEM_HK_SEL=0.
- K sweep with K_RADDR=0..63 -> each K_VALID returns the matching K constant (0→428a2f98, 63→c67178f2), one accept every 3 cycles.
- H_REQ and K_REQ both held high from reset-release -> grant order H, K, H, K; only one VALID high per cycle.
- REINIT pulsed during WAIT of K_RADDR=5 -> K_VALID delivers 59f111f1, then MEM_COPY_ROM=1 and READY=0 until done.
- MEM_COPY_DONE never asserted, COPY_TIMEOUT=16 -> COPY_ERR=1 after 16 cycles, no GNTs; REINIT then done -> COPY_ERR=0, READY=1. RST_N pulled low mid-WAIT -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/hk_pkg.sv
// Shared types and widths for the H/K constant-memory controller.
package hk_pkg;
  localparam int unsigned H_AW = 3;
  localparam int unsigned K_AW = 6;
  localparam int unsigned HK_W = 32;

  typedef enum logic [2:0] {
    COPY = 3'd0,
    IDLE = 3'd1,
    WAIT = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  typedef enum logic {
    HSEL = 1'b0,
    KSEL = 1'b1
  } sel_t;
endpackage

// File: rtl/hk_mem_ctrl_if.sv
// Bundle of memory-side and requester-side signals around hk_mem_ctrl.
interface hk_mem_ctrl_if;
  import hk_pkg::*;

  logic              REINIT;
  logic              MEM_COPY_ROM;
  logic              MEM_COPY_DONE;
  logic              MEM_HK_SEL;
  logic [H_AW-1:0]   MEM_H_ADDR;
  logic [K_AW-1:0]   MEM_K_ADDR;
  logic [HK_W-1:0]   MEM_HK;
  logic              READY;
  logic              COPY_ERR;
  logic              H_REQ;
  logic [H_AW-1:0]   H_RADDR;
  logic              H_GNT;
  logic              H_VALID;
  logic              K_REQ;
  logic [K_AW-1:0]   K_RADDR;
  logic              K_GNT;
  logic              K_VALID;
  logic [HK_W-1:0]   RD_DATA;

  // Controller side
  modport slave (
    input  REINIT, MEM_COPY_DONE, MEM_HK, H_REQ, H_RADDR, K_REQ, K_RADDR,
    output MEM_COPY_ROM, MEM_HK_SEL, MEM_H_ADDR, MEM_K_ADDR, READY, COPY_ERR,
           H_GNT, H_VALID, K_GNT, K_VALID, RD_DATA
  );

  // Environment side (memory + requesters)
  modport master (
    output REINIT, MEM_COPY_DONE, MEM_HK, H_REQ, H_RADDR, K_REQ, K_RADDR,
    input  MEM_COPY_ROM, MEM_HK_SEL, MEM_H_ADDR, MEM_K_ADDR, READY, COPY_ERR,
           H_GNT, H_VALID, K_GNT, K_VALID, RD_DATA
  );
endinterface

// File: rtl/hk_rr_arb.sv
// Two-way round-robin arbiter: on a tie the side that was not granted last wins.
module hk_rr_arb
  import hk_pkg::*;
(
  input  logic req_h_i,
  input  logic req_k_i,
  input  sel_t last_i,
  output logic gnt_h_o,
  output logic gnt_k_o
);
  always_comb begin
    gnt_h_o = req_h_i && (!req_k_i || (last_i == KSEL));
    gnt_k_o = req_k_i && !gnt_h_o;
  end
endmodule

// File: rtl/hk_mem_ctrl.sv
// Sequences the ROM-to-RAM copy after reset, then arbitrates H/K reads over the
// single HK read port, holding selector/address for READ_LAT cycles.
module hk_mem_ctrl
  import hk_pkg::*;
#(
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned COPY_TIMEOUT = 1024
) (
  input  logic          CLK,
  input  logic          RST_N,
  hk_mem_ctrl_if.slave  bus
);
  localparam logic [15:0] TMO_LAST = 16'(COPY_TIMEOUT - 1);
  localparam logic [2:0]  LAT_LAST = 3'(READ_LAT - 1);

  state_t            state_q, state_d;
  sel_t              last_q, last_d;
  sel_t              sel_q, sel_d;
  logic [H_AW-1:0]   haddr_q, haddr_d;
  logic [K_AW-1:0]   kaddr_q, kaddr_d;
  logic [HK_W-1:0]   rdata_q, rdata_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [2:0]        lat_q, lat_d;
  logic              pend_q, pend_d;
  logic              arb_h, arb_k;

  hk_rr_arb u_arb (
    .req_h_i (bus.H_REQ),
    .req_k_i (bus.K_REQ),
    .last_i  (last_q),
    .gnt_h_o (arb_h),
    .gnt_k_o (arb_k)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= COPY;
      last_q  <= KSEL;
      sel_q   <= HSEL;
      haddr_q <= '0;
      kaddr_q <= '0;
      rdata_q <= '0;
      tmo_q   <= '0;
      lat_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      haddr_q <= haddr_d;
      kaddr_q <= kaddr_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
      lat_q   <= lat_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    haddr_d = haddr_q;
    kaddr_d = kaddr_q;
    rdata_d = rdata_q;
    tmo_d   = '0;
    lat_d   = lat_q;
    pend_d  = pend_q;
    unique case (state_q)
      COPY: begin
        if (bus.MEM_COPY_DONE)     state_d = IDLE;
        else if (tmo_q == TMO_LAST) state_d = ERR;
        else                        tmo_d   = tmo_q + 16'd1;
      end
      ERR: begin
        if (bus.REINIT) state_d = COPY;
      end
      IDLE: begin
        if (bus.REINIT) begin
          state_d = COPY;
        end else if (arb_h) begin
          sel_d   = HSEL;
          last_d  = HSEL;
          haddr_d = bus.H_RADDR;
          state_d = WAIT;
        end else if (arb_k) begin
          sel_d   = KSEL;
          last_d  = KSEL;
          kaddr_d = bus.K_RADDR;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // REINIT seen mid-read is remembered so the read still completes first.
        // Data is captured on the last hold cycle so RD_DATA is valid with the strobe.
        pend_d = pend_q | bus.REINIT;
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          rdata_d = bus.MEM_HK;
          state_d = RESP;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      RESP: begin
        pend_d  = 1'b0;
        state_d = (bus.REINIT || pend_q) ? COPY : IDLE;
      end
      default: state_d = COPY;
    endcase
  end

  always_comb begin
    bus.MEM_COPY_ROM = (state_q == COPY);
    bus.READY        = (state_q == IDLE) || (state_q == WAIT) || (state_q == RESP);
    bus.COPY_ERR     = (state_q == ERR);
    bus.H_GNT        = (state_q == IDLE) && !bus.REINIT && arb_h;
    bus.K_GNT        = (state_q == IDLE) && !bus.REINIT && arb_k;
    bus.H_VALID      = (state_q == RESP) && (sel_q == HSEL);
    bus.K_VALID      = (state_q == RESP) && (sel_q == KSEL);
    bus.MEM_HK_SEL   = sel_q;
    bus.MEM_H_ADDR   = haddr_q;
    bus.MEM_K_ADDR   = kaddr_q;
    bus.RD_DATA      = rdata_q;
  end
endmodule

// File: tb/tb_hk_mem_ctrl.sv
// Self-checking bench for hk_mem_ctrl: directed copy/arbitration/reinit/reset
// sequences, a vector table, and a randomized phase against a queue-based model.
module tb_hk_mem_ctrl;
  localparam int unsigned RL = 1;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  hk_mem_ctrl_if bus();
  hk_mem_ctrl_if tob();

  hk_mem_ctrl #(.READ_LAT(RL), .COPY_TIMEOUT(1024)) u_dut (.CLK(clk), .RST_N(rst_n), .bus(bus));
  hk_mem_ctrl #(.READ_LAT(RL), .COPY_TIMEOUT(16))   u_to  (.CLK(clk), .RST_N(rst_n), .bus(tob));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] HROM [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] KROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  // Memory model: address/selector are held for the whole latency window.
  always_comb bus.MEM_HK = bus.MEM_HK_SEL ? KROM[bus.MEM_K_ADDR] : HROM[bus.MEM_H_ADDR];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rst(input string nm, input logic rom, input logic [47:0] rest);
    chk({nm, "_rom"}, 64'(rom), 64'(1));
    chk({nm, "_outs"}, 64'(rest), 64'(0));
  endtask

  // Reference model: outstanding reads as {due cycle, side, data}, round-robin by last winner.
  typedef struct { int due; logic k; logic [31:0] d; } rd_t;
  rd_t         q[$];
  int          cyc;
  logic        mon_en = 1'b0;
  logic        last_k;
  logic        hg_seen, kg_seen;
  logic        eh, ek, gh, gk, idle_m;
  logic [31:0] ed;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      last_k = 1'b1;
      cyc = 0;
      hg_seen = 1'b0;
      kg_seen = 1'b0;
    end else begin
      cyc++;
      hg_seen = bus.H_GNT;
      kg_seen = bus.K_GNT;
      if (mon_en) begin
        eh = 1'b0; ek = 1'b0; ed = '0;
        if (q.size() != 0 && q[0].due == cyc) begin
          ek = q[0].k; eh = !q[0].k; ed = q[0].d;
        end
        idle_m = (q.size() == 0);
        gh = idle_m && bus.H_REQ && (!bus.K_REQ || last_k);
        gk = idle_m && bus.K_REQ && !gh;
        chk("mon_gnt", 64'({bus.H_GNT, bus.K_GNT}), 64'({gh, gk}));
        chk("mon_vld", 64'({bus.H_VALID, bus.K_VALID}), 64'({eh, ek}));
        if (eh || ek) begin
          chk("mon_data", 64'(bus.RD_DATA), 64'(ed));
          void'(q.pop_front());
        end
        if (gh || gk) begin
          q.push_back('{cyc + int'(RL) + 1, gk, gk ? KROM[bus.K_RADDR] : HROM[bus.H_RADDR]});
          last_k = gk;
        end
      end
    end
  end

  typedef struct { logic is_k; logic [5:0] addr; logic [31:0] exp; } vec_t;
  vec_t vecs [7];

  task automatic do_read(input logic is_k, input logic [5:0] a, input logic [31:0] exp, input string nm);
    logic got;
    @(posedge clk); #1;
    if (is_k) begin bus.K_REQ = 1'b1; bus.K_RADDR = a; end
    else begin bus.H_REQ = 1'b1; bus.H_RADDR = a[2:0]; end
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      #2;
      got = is_k ? bus.K_GNT : bus.H_GNT;
      if (!got) begin @(posedge clk); #1; end
    end
    chk({nm, "_gnt"}, 64'(got), 64'(1));
    @(posedge clk); #1;
    bus.H_REQ = 1'b0; bus.K_REQ = 1'b0;
    if (!got) return;
    chk({nm, "_sel"}, 64'(bus.MEM_HK_SEL), 64'(is_k));
    chk({nm, "_addr"}, is_k ? 64'(bus.MEM_K_ADDR) : 64'(bus.MEM_H_ADDR), is_k ? 64'(a) : 64'(a[2:0]));
    for (int unsigned i = 1; i <= RL; i++) begin
      chk({nm, "_early"}, 64'({bus.H_VALID, bus.K_VALID}), 64'(0));
      @(posedge clk); #1;
    end
    chk({nm, "_vld"}, 64'({bus.H_VALID, bus.K_VALID}), is_k ? 64'(1) : 64'(2));
    chk({nm, "_data"}, 64'(bus.RD_DATA), 64'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic  seq [4];
  int    gcyc [4];
  int    nseq, ng, lastw;

  initial begin
    vecs[0] = '{1'b0, 6'd0,  32'h6a09e667};
    vecs[1] = '{1'b0, 6'd7,  32'h5be0cd19};
    vecs[2] = '{1'b1, 6'd0,  32'h428a2f98};
    vecs[3] = '{1'b1, 6'd63, 32'hc67178f2};
    vecs[4] = '{1'b1, 6'd5,  32'h59f111f1};
    vecs[5] = '{1'b0, 6'd3,  32'ha54ff53a};
    vecs[6] = '{1'b1, 6'd31, 32'h14292967};

    rst_n = 1'b0;
    bus.REINIT = 1'b0; bus.MEM_COPY_DONE = 1'b0;
    bus.H_REQ = 1'b0; bus.H_RADDR = '0; bus.K_REQ = 1'b0; bus.K_RADDR = '0;
    tob.REINIT = 1'b0; tob.MEM_COPY_DONE = 1'b0; tob.MEM_HK = '0;
    tob.H_REQ = 1'b0; tob.H_RADDR = '0; tob.K_REQ = 1'b0; tob.K_RADDR = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_rst("rst", bus.MEM_COPY_ROM, {bus.READY, bus.COPY_ERR, bus.H_GNT, bus.K_GNT, bus.H_VALID,
            bus.K_VALID, bus.MEM_HK_SEL, bus.MEM_H_ADDR, bus.MEM_K_ADDR, bus.RD_DATA});

    // Copy phase: both requesters already asking; timeout instance runs alongside.
    bus.H_REQ = 1'b1; bus.K_REQ = 1'b1; tob.H_REQ = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      chk("copy_rom", 64'(bus.MEM_COPY_ROM), 64'(1));
      chk("copy_quiet", 64'({bus.READY, bus.H_GNT, bus.K_GNT}), 64'(0));
      if (c <= 25) chk("to_nogrant", 64'({tob.H_GNT, tob.K_GNT}), 64'(0));
      if (c == 15) chk("to_err_pre", 64'(tob.COPY_ERR), 64'(0));
      if (c == 16) chk("to_err", 64'({tob.COPY_ERR, tob.MEM_COPY_ROM, tob.READY}), 64'(3'b100));
      if (c == 20) tob.REINIT = 1'b1;
      if (c == 21) begin
        chk("to_reinit", 64'({tob.COPY_ERR, tob.MEM_COPY_ROM}), 64'(2'b01));
        tob.REINIT = 1'b0;
      end
      if (c == 25) begin tob.MEM_COPY_DONE = 1'b1; tob.H_REQ = 1'b0; end
      if (c == 26) begin
        chk("to_ready", 64'({tob.READY, tob.COPY_ERR, tob.MEM_COPY_ROM}), 64'(3'b100));
        tob.MEM_COPY_DONE = 1'b0;
      end
      if (c == 200) bus.MEM_COPY_DONE = 1'b1;
    end
    @(posedge clk); #1;
    bus.MEM_COPY_DONE = 1'b0;
    chk("ready", 64'({bus.READY, bus.MEM_COPY_ROM, bus.COPY_ERR}), 64'(3'b100));
    mon_en = 1'b1;

    // Both held from release: expect H, K, H, K spaced READ_LAT+2 apart.
    nseq = 0;
    for (int w = 0; w < 40 && nseq < 4; w++) begin
      @(negedge clk);
      if (bus.H_GNT || bus.K_GNT) begin
        seq[nseq] = bus.K_GNT; gcyc[nseq] = w; nseq++;
      end
    end
    @(posedge clk); #1;
    bus.H_REQ = 1'b0; bus.K_REQ = 1'b0;
    chk("both_count", 64'(nseq), 64'(4));
    for (int i = 0; i < nseq; i++) begin
      chk("both_order", 64'(seq[i]), 64'(i % 2));
      if (i > 0) chk("both_gap", 64'(gcyc[i] - gcyc[i-1]), 64'(RL + 2));
    end
    repeat (4) @(posedge clk);

    for (int i = 0; i < 7; i++)
      do_read(vecs[i].is_k, vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));

    // K sweep with REQ held: one accept every READ_LAT+2 cycles.
    @(posedge clk); #1;
    bus.K_REQ = 1'b1; bus.K_RADDR = '0; ng = 0; lastw = 0;
    for (int w = 0; w < 64 * int'(RL + 2) + 20 && ng < 64; w++) begin
      @(negedge clk);
      if (bus.K_GNT) begin
        if (ng > 0) chk("sweep_gap", 64'(w - lastw), 64'(RL + 2));
        lastw = w; ng++;
        @(posedge clk); #1;
        bus.K_RADDR = 6'(ng);
        if (ng == 64) bus.K_REQ = 1'b0;
      end
    end
    chk("sweep_count", 64'(ng), 64'(64));
    bus.K_REQ = 1'b0;

    // Randomized requesters, each REQ held until its GNT.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (hg_seen) bus.H_REQ = 1'b0;
      if (kg_seen) bus.K_REQ = 1'b0;
      if (!bus.H_REQ && $urandom_range(2) == 0) begin bus.H_REQ = 1'b1; bus.H_RADDR = 3'($urandom); end
      if (!bus.K_REQ && $urandom_range(2) == 0) begin bus.K_REQ = 1'b1; bus.K_RADDR = 6'($urandom); end
    end
    @(posedge clk); #1;
    if (hg_seen) bus.H_REQ = 1'b0;
    if (kg_seen) bus.K_REQ = 1'b0;
    for (int w = 0; w < 20 && (bus.H_REQ || bus.K_REQ); w++) begin
      @(posedge clk); #1;
      if (hg_seen) bus.H_REQ = 1'b0;
      if (kg_seen) bus.K_REQ = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1;
    chk("mon_drain", 64'(q.size()), 64'(0));
    mon_en = 1'b0;

    // REINIT pulsed during WAIT of K[5].
    bus.K_REQ = 1'b1; bus.K_RADDR = 6'd5;
    #2 chk("ri_gnt", 64'(bus.K_GNT), 64'(1));
    @(posedge clk); #1;
    bus.K_REQ = 1'b0; bus.REINIT = 1'b1;
    chk("ri_wait", 64'({bus.READY, bus.K_VALID}), 64'(2'b10));
    @(posedge clk); #1;
    bus.REINIT = 1'b0;
    repeat (RL - 1) begin @(posedge clk); #1; end
    chk("ri_valid", 64'({bus.K_VALID, bus.H_VALID, bus.READY, bus.MEM_COPY_ROM}), 64'(4'b1010));
    chk("ri_data", 64'(bus.RD_DATA), 64'(32'h59f111f1));
    bus.H_REQ = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("ri_copy", 64'({bus.MEM_COPY_ROM, bus.READY, bus.H_GNT, bus.K_GNT}), 64'(4'b1000));
    end
    bus.H_REQ = 1'b0; bus.MEM_COPY_DONE = 1'b1;
    @(posedge clk); #1;
    bus.MEM_COPY_DONE = 1'b0;
    chk("ri_ready", 64'({bus.READY, bus.MEM_COPY_ROM}), 64'(2'b10));

    // Asynchronous reset in the middle of a K read.
    bus.K_REQ = 1'b1; bus.K_RADDR = 6'd9;
    @(posedge clk); #1;
    bus.K_REQ = 1'b0;
    chk("pre_rst", 64'({bus.MEM_HK_SEL, bus.MEM_K_ADDR}), 64'({1'b1, 6'd9}));
    #2 rst_n = 1'b0;
    #1;
    chk_rst("arst", bus.MEM_COPY_ROM, {bus.READY, bus.COPY_ERR, bus.H_GNT, bus.K_GNT, bus.H_VALID,
            bus.K_VALID, bus.MEM_HK_SEL, bus.MEM_H_ADDR, bus.MEM_K_ADDR, bus.RD_DATA});
    chk_rst("arst_to", tob.MEM_COPY_ROM, {tob.READY, tob.COPY_ERR, tob.H_GNT, tob.K_GNT, tob.H_VALID,
            tob.K_VALID, tob.MEM_HK_SEL, tob.MEM_H_ADDR, tob.MEM_K_ADDR, tob.RD_DATA});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
